// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with taken-branch PCSrc tracking; 1-clock latency input to output.
// Backpressure: stall holds all state, and flush loads a bubble with priority over stall.
module ex_mem_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] ALU_result,
    input  logic        Zero_signal,
    input  logic [31:0] branch_target,
    input  logic [31:0] data_read_2,
    input  logic [4:0]  write_reg,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    output logic [31:0] mem_ALU_result,
    output logic [31:0] mem_branch_target,
    output logic [31:0] mem_data_write,
    output logic        mem_Zero,
    output logic [4:0]  mem_write_reg,
    output logic        mem_Branch,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic        mem_RegWrite,
    output logic        mem_MemtoReg,
    output logic        mem_valid,
    output logic        PCSrc
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ISSUED = 1'b1;

    logic [31:0] r_alu_result;
    logic [31:0] r_branch_target;
    logic [31:0] r_data_write;
    logic        r_zero;
    logic [4:0]  r_write_reg;
    logic        r_branch;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_valid;
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        w_pcsrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            r_alu_result    <= 32'd0;
            r_branch_target <= 32'd0;
            r_data_write    <= 32'd0;
            r_zero          <= 1'b0;
            r_write_reg     <= 5'd0;
            r_branch        <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_valid         <= 1'b0;
        end else if (!stall) begin
            r_alu_result    <= ALU_result;
            r_branch_target <= branch_target;
            r_data_write    <= data_read_2;
            r_zero          <= Zero_signal;
            r_write_reg     <= write_reg;
            // Control bits are qualified so a bubble can never write memory, registers or redirect the PC.
            r_branch        <= Branch   & in_valid;
            r_mem_read      <= MemRead  & in_valid;
            r_mem_write     <= MemWrite & in_valid;
            r_reg_write     <= RegWrite & in_valid;
            r_mem_to_reg    <= MemtoReg & in_valid;
            r_valid         <= in_valid;
        end
    end

    assign w_pcsrc = r_valid & r_branch & r_zero & (r_state == IDLE);

    // A taken branch held by stall redirects the PC once; ISSUED masks the repeats.
    always_comb begin
        w_state_nxt = r_state;
        if (flush || !stall)
            w_state_nxt = IDLE;
        else if (w_pcsrc)
            w_state_nxt = ISSUED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    assign mem_ALU_result    = r_alu_result;
    assign mem_branch_target = r_branch_target;
    assign mem_data_write    = r_data_write;
    assign mem_Zero          = r_zero;
    assign mem_write_reg     = r_write_reg;
    assign mem_Branch        = r_branch;
    assign mem_MemRead       = r_mem_read;
    assign mem_MemWrite      = r_mem_write;
    assign mem_RegWrite      = r_reg_write;
    assign mem_MemtoReg      = r_mem_to_reg;
    assign mem_valid         = r_valid;
    assign PCSrc             = w_pcsrc;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: load, taken/stalled branch, bubble, flush priority, async reset.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] ALU_result, branch_target, data_read_2;
    logic        Zero_signal;
    logic [4:0]  write_reg;
    logic        Branch, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] mem_ALU_result, mem_branch_target, mem_data_write;
    logic        mem_Zero;
    logic [4:0]  mem_write_reg;
    logic        mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg;
    logic        mem_valid, PCSrc;

    int n_assert = 0;
    int n_fail   = 0;

    ex_mem_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .ALU_result(ALU_result), .Zero_signal(Zero_signal), .branch_target(branch_target),
        .data_read_2(data_read_2), .write_reg(write_reg),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg),
        .mem_ALU_result(mem_ALU_result), .mem_branch_target(mem_branch_target),
        .mem_data_write(mem_data_write), .mem_Zero(mem_Zero), .mem_write_reg(mem_write_reg),
        .mem_Branch(mem_Branch), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_valid(mem_valid), .PCSrc(PCSrc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu"},  mem_ALU_result, 32'd0);
        check({tag, ".bt"},   mem_branch_target, 32'd0);
        check({tag, ".dw"},   mem_data_write, 32'd0);
        check({tag, ".misc"}, {20'd0, mem_Zero, mem_write_reg, mem_Branch, mem_MemRead,
                               mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_valid}, 32'd0);
        check({tag, ".pcsrc"}, {31'd0, PCSrc}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] alu, input logic z,
                             input logic [31:0] bt, input logic [31:0] d2, input logic [4:0] wr,
                             input logic br, input logic mr, input logic mw,
                             input logic rw, input logic m2r);
        in_valid = v; ALU_result = alu; Zero_signal = z; branch_target = bt;
        data_read_2 = d2; write_reg = wr; Branch = br; MemRead = mr; MemWrite = mw;
        RegWrite = rw; MemtoReg = m2r;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check_all_zero("reset");
        step();
        check_all_zero("reset_edge");
        @(negedge clk);
        reset = 1'b0;

        // Plain load
        set_instr(1'b1, 32'h0000_0055, 1'b0, 32'h0000_0100, 32'hA5A5_0001, 5'd5,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("load.alu", mem_ALU_result, 32'h55);
        check("load.wr", {27'd0, mem_write_reg}, 32'd5);
        check("load.rw", {31'd0, mem_RegWrite}, 32'd1);
        check("load.valid", {31'd0, mem_valid}, 32'd1);
        check("load.pcsrc", {31'd0, PCSrc}, 32'd0);
        check("load.dw", mem_data_write, 32'hA5A5_0001);
        check("load.bt", mem_branch_target, 32'h100);

        // Taken branch
        set_instr(1'b1, 32'd0, 1'b1, 32'h0000_0040, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("br.pcsrc", {31'd0, PCSrc}, 32'd1);
        check("br.bt", mem_branch_target, 32'h40);
        set_instr(1'b1, 32'd0, 1'b1, 32'h0000_0080, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("nobr.pcsrc", {31'd0, PCSrc}, 32'd0);
        check("nobr.bt", mem_branch_target, 32'h80);

        // Stalled taken branch: one PCSrc pulse only
        set_instr(1'b1, 32'd0, 1'b1, 32'h0000_0040, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("sbr.pcsrc0", {31'd0, PCSrc}, 32'd1);
        stall = 1'b1;
        set_instr(1'b1, 32'h0000_1234, 1'b1, 32'h0000_0099, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sbr.pcsrc%0d", i + 1), {31'd0, PCSrc}, 32'd0);
            check($sformatf("sbr.bt%0d", i + 1), mem_branch_target, 32'h40);
            check($sformatf("sbr.alu%0d", i + 1), mem_ALU_result, 32'd0);
        end
        stall = 1'b0;
        set_instr(1'b1, 32'd0, 1'b1, 32'h0000_0060, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("rel.pcsrc", {31'd0, PCSrc}, 32'd1);
        check("rel.bt", mem_branch_target, 32'h60);

        // Bubble with branch and store bits set
        set_instr(1'b0, 32'h0000_0077, 1'b1, 32'h0000_0044, 32'h0000_0011, 5'd3,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check("bub.mw", {31'd0, mem_MemWrite}, 32'd0);
        check("bub.valid", {31'd0, mem_valid}, 32'd0);
        check("bub.pcsrc", {31'd0, PCSrc}, 32'd0);
        check("bub.ctrl", {27'd0, mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite,
                           mem_MemtoReg}, 32'd0);
        check("bub.alu", mem_ALU_result, 32'h77);

        // Flush beats stall, including from ISSUED
        set_instr(1'b1, 32'h0000_00AA, 1'b1, 32'h0000_0040, 32'h0000_0022, 5'd7,
                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        check("fl.pre_valid", {31'd0, mem_valid}, 32'd1);
        stall = 1'b1;
        step();
        check("fl.issued_pcsrc", {31'd0, PCSrc}, 32'd0);
        flush = 1'b1;
        step();
        check_all_zero("flush");
        flush = 1'b0;
        stall = 1'b0;

        // Async reset mid-stall with PCSrc high
        set_instr(1'b1, 32'h0000_0033, 1'b1, 32'h0000_0040, 32'h0000_0044, 5'd2,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("ar.pre_pcsrc", {31'd0, PCSrc}, 32'd1);
        check("ar.pre_valid", {31'd0, mem_valid}, 32'd1);
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        check_all_zero("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        step();
        check("post.valid", {31'd0, mem_valid}, 32'd1);
        check("post.pcsrc", {31'd0, PCSrc}, 32'd1);
        check("post.alu", mem_ALU_result, 32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
